// File: rtl/byte_queue_if.sv
// Handshake bundle between the receiver (producer), the byte queue and the sender (consumer).
// master = the side that pushes bytes and accepts the head; slave = the queue itself.
interface byte_queue_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  overflow;

    modport master (
        output wr_data, wr_en, rd_ready,
        input  rd_data, rd_valid, level, full, overflow
    );

    modport slave (
        input  wr_data, wr_en, rd_ready,
        output rd_data, rd_valid, level, full, overflow
    );
endinterface

// File: rtl/byte_queue.sv
// Show-ahead byte FIFO with registered head, fill level and sticky overflow flag.
// A push into an empty queue shows up on rd_data one clock later.
module byte_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    byte_queue_if.slave   bq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_head;

    logic                  w_full;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_next;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_next;
    logic [DEPTH_LOG2:0]   w_level_next;
    logic [DATA_WIDTH-1:0] w_head_next;

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid && bq.rd_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push  = bq.wr_en && (!w_full || w_pop);
    assign w_drop  = bq.wr_en && w_full && !w_pop;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_level_next  = r_level;
        if (w_push) begin
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_ONE;
            2'b01:   w_level_next = r_level - LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    // The next head may be the byte being written this very cycle, so bypass the array.
    always_comb begin
        w_head_next = r_mem[w_rd_ptr_next];
        if (w_level_next == '0) begin
            w_head_next = '0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = bq.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bq.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_head     <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
            r_head   <= w_head_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bq.rd_data  = r_head;
    assign bq.rd_valid = w_valid;
    assign bq.level    = r_level;
    assign bq.full     = w_full;
    assign bq.overflow = r_overflow;
endmodule

// File: tb/tb_byte_queue.sv
// Directed self-checking bench for byte_queue at depth 4; each task owns one scenario.
module tb_byte_queue;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    byte_queue_if #(.DEPTH_LOG2(2), .DATA_WIDTH(8)) bq ();

    byte_queue #(.DEPTH_LOG2(2), .DATA_WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bq    (bq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("reset");
    endtask

    task automatic push(input logic [7:0] b);
        bq.wr_en   = 1'b1;
        bq.wr_data = b;
        step();
        bq.wr_en   = 1'b0;
        $display("push %02h level=%0d overflow=%0b", b, bq.level, bq.overflow);
    endtask

    task automatic pop();
        bq.rd_ready = 1'b1;
        step();
        bq.rd_ready = 1'b0;
        $display("pop  level=%0d rd_valid=%0b", bq.level, bq.rd_valid);
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bq.level); end
        checks++; if (bq.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", bq.rd_valid); end
        checks++; if (bq.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bq.full); end
        checks++; if (bq.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bq.overflow); end
        checks++; if (bq.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%02h exp=00", bq.rd_data); end
    endtask

    task automatic test_single();
        push(8'h41);
        checks++; if (bq.rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", bq.rd_valid); end
        checks++; if (bq.rd_data !== 8'h41) begin failures++; $display("FAIL single_data got=%02h exp=41", bq.rd_data); end
        checks++; if (bq.level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", bq.level); end
        pop();
        checks++; if (bq.rd_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%0b exp=0", bq.rd_valid); end
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL single_pop_level got=%0d exp=0", bq.level); end
        // Reading an empty queue must not underflow.
        pop();
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL underflow_level got=%0d exp=0", bq.level); end
        checks++; if (bq.rd_valid !== 1'b0) begin failures++; $display("FAIL underflow_valid got=%0b exp=0", bq.rd_valid); end
        push(8'h42);
        checks++; if (bq.rd_data !== 8'h42) begin failures++; $display("FAIL underflow_next_data got=%02h exp=42", bq.rd_data); end
        pop();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 1; i <= 4; i++) push(8'(i));
        checks++; if (bq.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0b exp=1", bq.full); end
        checks++; if (bq.level !== 3'd4) begin failures++; $display("FAIL ovf_level4 got=%0d exp=4", bq.level); end
        checks++; if (bq.overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%0b exp=0", bq.overflow); end
        push(8'h05);
        checks++; if (bq.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bq.overflow); end
        checks++; if (bq.level !== 3'd4) begin failures++; $display("FAIL ovf_level_after got=%0d exp=4", bq.level); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            checks++; if (bq.rd_valid !== 1'b1 || bq.rd_data !== exp_b) begin
                failures++; $display("FAIL ovf_drain%0d got=%02h/v%0b exp=%02h/v1", i, bq.rd_data, bq.rd_valid, exp_b);
            end
            pop();
        end
        checks++; if (bq.rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b exp=0", bq.rd_valid); end
        checks++; if (bq.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", bq.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'hAA};
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        bq.wr_en    = 1'b1;
        bq.wr_data  = 8'hAA;
        bq.rd_ready = 1'b1;
        step();
        bq.wr_en    = 1'b0;
        bq.rd_ready = 1'b0;
        $display("push AA + pop level=%0d", bq.level);
        checks++; if (bq.level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d exp=4", bq.level); end
        checks++; if (bq.overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%0b exp=0", bq.overflow); end
        checks++; if (bq.full !== 1'b1) begin failures++; $display("FAIL fpp_full got=%0b exp=1", bq.full); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bq.rd_valid !== 1'b1 || bq.rd_data !== exp_q[i]) begin
                failures++; $display("FAIL fpp_drain%0d got=%02h/v%0b exp=%02h/v1", i, bq.rd_data, bq.rd_valid, exp_q[i]);
            end
            pop();
        end
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL fpp_empty got=%0d exp=0", bq.level); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        for (int r = 0; r < 10; r++) begin
            v = 8'(8'h10 + 2 * r);
            push(v);
            push(v + 8'd1);
            checks++; if (bq.level !== 3'd2) begin failures++; $display("FAIL wrap_level2_r%0d got=%0d exp=2", r, bq.level); end
            checks++; if (bq.rd_data !== v) begin failures++; $display("FAIL wrap_first_r%0d got=%02h exp=%02h", r, bq.rd_data, v); end
            pop();
            checks++; if (bq.rd_data !== v + 8'd1) begin failures++; $display("FAIL wrap_second_r%0d got=%02h exp=%02h", r, bq.rd_data, v + 8'd1); end
            pop();
            checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL wrap_level0_r%0d got=%0d exp=0", r, bq.level); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        push(8'hCF);
        pop();
        checks++; if (bq.level !== 3'd3 || bq.overflow !== 1'b1) begin
            failures++; $display("FAIL mid_setup got=%0d/o%0b exp=3/o1", bq.level, bq.overflow);
        end
        reset      = 1'b1;
        bq.wr_en   = 1'b1;
        bq.wr_data = 8'h99;
        step();
        reset    = 1'b0;
        bq.wr_en = 1'b0;
        $display("reset with push 99");
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", bq.level); end
        checks++; if (bq.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", bq.rd_valid); end
        checks++; if (bq.overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow got=%0b exp=0", bq.overflow); end
        step();
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL mid_idle_level got=%0d exp=0", bq.level); end
        push(8'h55);
        checks++; if (bq.rd_data !== 8'h55 || bq.level !== 3'd1) begin
            failures++; $display("FAIL mid_first got=%02h/l%0d exp=55/l1", bq.rd_data, bq.level);
        end
        pop();
        checks++; if (bq.level !== 3'd0) begin failures++; $display("FAIL mid_final_level got=%0d exp=0", bq.level); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bq.wr_en    = 1'b0;
        bq.wr_data  = 8'h00;
        bq.rd_ready = 1'b0;
        step();
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
